// File: rtl/function_codes_pkg.sv
// Shared instruction function codes and execute-stage sequencing types.
package function_codes_pkg;

    // {funct7, funct3} for the OP/OP-IMM integer group
    typedef enum logic [9:0] {
        ADD  = 10'h000,
        SLL  = 10'h001,
        SLT  = 10'h002,
        SLTU = 10'h003,
        XOR  = 10'h004,
        SRL  = 10'h005,
        OR   = 10'h006,
        AND  = 10'h007,
        SUB  = 10'h100,
        SRA  = 10'h105
    } funct7_func3_t;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_func3_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } alu_seq_state_t;

    typedef enum logic [1:0] {
        SH_LL,
        SH_RL,
        SH_RA
    } shift_kind_t;

    localparam int unsigned SHAMT_W = $clog2(32);

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation with illegal-code detection.
module branch_compare
    import function_codes_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  branch_func3_t   funct,
    output logic            taken,
    output logic            illegal
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (a == b);
    assign lt_s = ($signed(a) < $signed(b));
    assign lt_u = (a < b);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct)
            BEQ:     taken = eq;
            BNE:     taken = !eq;
            BLT:     taken = lt_s;
            BGE:     taken = !lt_s;
            BLTU:    taken = lt_u;
            BGEU:    taken = !lt_u;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/iterative_alu_ctrl.sv
// Execute-stage ALU sequencer: single-cycle logic/arith/compare, iterative shifts,
// results held on a valid/ready output until consumed.
module iterative_alu_ctrl
    import function_codes_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_branch,
    input  logic [9:0]      in_funct,
    input  logic [2:0]      in_branch_funct,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_taken,
    output logic            out_illegal,
    output logic            busy
);

    localparam int unsigned SHW = $clog2(XLEN);
    // One extra bit so SHIFT_STEP == XLEN is representable
    localparam logic [SHW:0] STEP = (SHW + 1)'(SHIFT_STEP);

    alu_seq_state_t state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [SHW-1:0]  rem_q, rem_d;
    shift_kind_t     kind_q, kind_d;
    logic            sign_q, sign_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            taken_q, taken_d;
    logic            ill_q, ill_d;

    funct7_func3_t   funct;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic            is_shift;
    shift_kind_t     acc_kind;
    logic            br_taken;
    logic            br_ill;
    logic            accept;

    logic [SHW:0]    step;
    logic [XLEN-1:0] shifted;
    logic [SHW-1:0]  rem_next;

    assign funct  = funct7_func3_t'(in_funct);
    assign accept = in_valid && in_ready;

    branch_compare #(
        .XLEN(XLEN)
    ) u_branch_compare (
        .a      (in_a),
        .b      (in_b),
        .funct  (branch_func3_t'(in_branch_funct)),
        .taken  (br_taken),
        .illegal(br_ill)
    );

    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        acc_kind = SH_LL;
        case (funct)
            ADD:  alu_res = in_a + in_b;
            SUB:  alu_res = in_a - in_b;
            AND:  alu_res = in_a & in_b;
            OR:   alu_res = in_a | in_b;
            XOR:  alu_res = in_a ^ in_b;
            SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            SLL: begin
                is_shift = 1'b1;
                acc_kind = SH_LL;
            end
            SRL: begin
                is_shift = 1'b1;
                acc_kind = SH_RL;
            end
            SRA: begin
                is_shift = 1'b1;
                acc_kind = SH_RA;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    // step = min(SHIFT_STEP, remaining), so the last iteration never overshoots
    always_comb begin
        step = ({1'b0, rem_q} < STEP) ? {1'b0, rem_q} : STEP;
        rem_next = rem_q - step[SHW-1:0];
        case (kind_q)
            SH_LL:   shifted = a_q << step;
            SH_RL:   shifted = a_q >> step;
            SH_RA:   shifted = (a_q >> step) | (sign_q ? ~({XLEN{1'b1}} >> step) : '0);
            default: shifted = a_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        rem_d   = rem_q;
        kind_d  = kind_q;
        sign_d  = sign_q;
        res_d   = res_q;
        taken_d = taken_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HOLD;
                    res_d   = '0;
                    taken_d = 1'b0;
                    ill_d   = 1'b0;
                    if (in_is_branch) begin
                        taken_d = br_taken;
                        ill_d   = br_ill;
                    end else if (alu_ill) begin
                        ill_d = 1'b1;
                    end else if (is_shift) begin
                        a_d    = in_a;
                        rem_d  = in_b[SHW-1:0];
                        kind_d = acc_kind;
                        sign_d = in_a[XLEN-1];
                        if (in_b[SHW-1:0] == '0) begin
                            res_d = in_a;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        res_d = alu_res;
                    end
                end
            end
            SHIFT: begin
                a_d   = shifted;
                rem_d = rem_next;
                if (rem_next == '0) begin
                    res_d   = shifted;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            rem_q   <= '0;
            kind_q  <= SH_LL;
            sign_q  <= 1'b0;
            res_q   <= '0;
            taken_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            rem_q   <= rem_d;
            kind_q  <= kind_d;
            sign_q  <= sign_d;
            res_q   <= res_d;
            taken_q <= taken_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready    = (state_q == IDLE) && !rst;
    assign out_valid   = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign out_result  = res_q;
    assign out_taken   = taken_q;
    assign out_illegal = ill_q;

endmodule
